logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit bitwise AND unit, for use in the ALU datapath.
- Selects one of eight bitwise operations per transaction and returns the result one cycle later through a valid/ready output register.
- Optional accumulator mode: the previous result replaces operand a, so mask/merge chains run without external feedback.
- Sits between the ALU operand mux and the ALU result mux.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 1).
- ACC_INIT, 0, accumulator value after reset and after acc_clr (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept this cycle
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b
- op  in  3  operation select
- acc_en  in  1  use accumulator instead of a; write result back to accumulator
- acc_clr  in  1  load ACC_INIT into accumulator
- out_valid  out  1  result register holds unconsumed data
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  registered: result == 0

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, result=0, zero=1, accumulator=ACC_INIT.
  - Any transfer in that cycle is discarded.
  - Reset mid-stream drops the held result.
- in_ready = !out_valid || out_ready (combinational). Input transfer (accept) = in_valid && in_ready.
- Output transfer = out_valid && out_ready. result and zero stay stable while out_valid && !out_ready.
- Latency: accepted at edge N -> result visible, out_valid=1 after edge N.
- Throughput: 1 per cycle when out_ready is held high.
- No accept while stalled: out_valid=0 stays 0; otherwise out_valid clears only on output transfer.
- Operand x = acc_en ? accumulator : a.
- op encoding:
  - 000 AND x&b
  - 001 OR x|b
  - 010 XOR x^b
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT ~x (b ignored)
  - 111 ANDN x&~b
- All ops are bitwise at WIDTH; there is no carry and no width growth.
- Accumulator update:
  - On accept with acc_en=1: accumulator <= computed result.
  - acc_clr=1 on a cycle, with or without accept: the accumulator is set to ACC_INIT first and that value is used as x for the same transaction. Its result still writes back if acc_en=1.
  - acc_clr without accept only clears.
  - acc_en=0 transactions never modify the accumulator.
- Simultaneous output transfer and accept in the same cycle: the new result loads and out_valid remains 1. There is no bubble.
- Inputs are ignored when in_valid=0. Signals a, b, op, acc_en and acc_clr are sampled only on accept, except that acc_clr also acts on its own as described above.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- Defined: adds two output ports, registered and updated together with result:
  - parity (1 bit): XOR-reduce of result.
  - all_ones (1 bit): result == all 1s.
  - Both are 0 after reset.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=8, out_ready=1: accept a=0x01, b=0x16, op=000 -> next cycle result=0x00, zero=1. Then accept a=0x07, b=0x0A, op=000 -> result=0x02, zero=0.
- Sweep all 8 ops with a=0xF0, b=0x3C -> in op order: 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0x0F, 0xC0. One result per cycle, no bubbles.
- Backpressure: hold out_ready=0 with result 0x30 pending -> in_ready=0, result held, new in_valid not accepted. Release out_ready -> transfer and accept occur in the same cycle, and the next result appears at the following edge.
- Accumulator chain, ACC_INIT=0xFF:
  - acc_en=1, op=000, b=0x0F -> result 0x0F.
  - Then acc_en=1, op=001, b=0x30 -> result 0x3F.
  - Then acc_clr=1 with acc_en=1, op=010, b=0x01 -> result 0xFE.
- Reset while out_valid=1 and out_ready=0 -> after the edge: out_valid=0, zero=1, accumulator=ACC_INIT. A later acc_en=1, op=110 -> result 0x00.
- WIDTH=16 with LOGIC_UNIT_FLAGS_EN: a=0x00FF, b=0xFFFF, op=101 -> result 0x00FF, parity=0, all_ones=0. Then op=001 -> 0xFFFF, all_ones=1, parity=0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered eight-op bitwise unit with optional accumulator operand
// Defining LOGIC_UNIT_FLAGS_EN adds registered parity and all_ones outputs.
module logic_unit_pipe #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
`ifdef LOGIC_UNIT_FLAGS_EN
   ,
   output logic             parity,
   output logic             all_ones
`endif
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] res_next;
   logic             accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle takes effect before the operand is chosen.
   assign acc_base = acc_clr ? ACC_INIT : acc_q;
   assign x        = acc_en ? acc_base : a;

   always_comb begin
      res_next = '0;
      case (op)
         3'b000:  res_next = x & b;
         3'b001:  res_next = x | b;
         3'b010:  res_next = x ^ b;
         3'b011:  res_next = ~(x & b);
         3'b100:  res_next = ~(x | b);
         3'b101:  res_next = ~(x ^ b);
         3'b110:  res_next = ~x;
         default: res_next = x & ~b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= res_next;
         zero      <= (res_next == '0);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= ACC_INIT;
      end else if (accept && acc_en) begin
         acc_q <= res_next;
      end else if (acc_clr) begin
         acc_q <= ACC_INIT;
      end
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity   <= 1'b0;
         all_ones <= 1'b0;
      end else if (accept) begin
         parity   <= ^res_next;
         all_ones <= &res_next;
      end
   end
`endif

endmodule
